// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader
//   Read-side engine for an HD44780 character-LCD bus. Performs one RW=1
//   bus cycle, reading either the status byte (BF + AC) or one DDRAM/CGRAM
//   data byte. It can optionally re-poll status until BF=0 or MAX_POLLS.
//   The result is returned to the requester as a one-cycle rd_valid pulse.
//
// Ports
//   clk, reset_n      : system clock; asynchronous active-low reset
//   rd_req            : start request, sampled only when idle
//   rd_rs             : 0 = status read, 1 = data read (latched on accept)
//   rd_wait           : poll status until BF=0 (ignored for data reads)
//   rd_busy           : transaction in progress (after accept, until done)
//   rd_valid          : one-cycle result strobe
//   rd_data           : captured byte, held until the next capture
//   rd_timeout        : with rd_valid, poll limit reached while still busy
//   lcd_data_in       : LCD data bus, read direction
//   bus_own           : reader drives RS/RW/E; top level releases LCD_DATA
//   lcd_e, lcd_rs,
//   lcd_rw            : LCD control strobes
module lcd_bus_reader #(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned E_HIGH_CYC = 12,
   parameter int unsigned SAMPLE_CYC = 10,
   parameter int unsigned HOLD_CYC   = 2,
   parameter int unsigned GAP_CYC    = 13,
   parameter int unsigned MAX_POLLS  = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rd_req,
   input  logic       rd_rs,
   input  logic       rd_wait,
   output logic       rd_busy,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       rd_timeout,
   input  logic [7:0] lcd_data_in,
   output logic       bus_own,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_EHIGH,
      ST_HOLD,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic [7:0]  poll_cnt;
   logic [7:0]  data_q;
   logic        rs_q;
   logic        wait_q;
   logic        sample_now;

   // capture happens on the edge that ends E-high cycle SAMPLE_CYC
   assign sample_now = (state == ST_EHIGH) && (cnt == 16'(SAMPLE_CYC - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (rd_req) state_nxt = ST_SETUP;
         ST_SETUP: if (cnt == 16'(SETUP_CYC - 1)) state_nxt = ST_EHIGH;
         ST_EHIGH: if (cnt == 16'(E_HIGH_CYC - 1)) state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (cnt == 16'(HOLD_CYC - 1)) begin
               // poll_cnt already includes the poll that just finished
               if (wait_q && data_q[7] && (poll_cnt < 8'(MAX_POLLS)))
                  state_nxt = ST_GAP;
               else
                  state_nxt = ST_DONE;
            end
         end
         ST_GAP:   if (cnt == 16'(GAP_CYC - 1)) state_nxt = ST_SETUP;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // phase counter restarts whenever the state changes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (state_nxt != state) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rs_q     <= 1'b0;
         wait_q   <= 1'b0;
         poll_cnt <= '0;
         data_q   <= '0;
      end else begin
         if (state == ST_IDLE && rd_req) begin
            rs_q     <= rd_rs;
            wait_q   <= rd_wait & ~rd_rs;
            poll_cnt <= '0;
         end
         if (sample_now) begin
            data_q <= lcd_data_in;
            if (poll_cnt != 8'(MAX_POLLS))
               poll_cnt <= poll_cnt + 8'd1;
         end
      end
   end

   // outputs decode directly from registers only
   assign bus_own    = (state == ST_SETUP) || (state == ST_EHIGH) ||
                       (state == ST_HOLD)  || (state == ST_GAP);
   assign lcd_rw     = bus_own;
   assign lcd_rs     = bus_own & rs_q;
   assign lcd_e      = (state == ST_EHIGH);
   assign rd_busy    = bus_own;
   assign rd_valid   = (state == ST_DONE);
   assign rd_timeout = (state == ST_DONE) & wait_q & data_q[7];
   assign rd_data    = data_q;

endmodule
